// File: rtl/video_pixel_frame_buffer.sv
// rtl/video_pixel_frame_buffer.sv - on-chip pixel frame buffer with slave port and raster scanout stream
// Port A serves CPU/DMA accesses; port B clears the RAM after reset, then feeds a 2-entry stream FIFO.
module video_pixel_frame_buffer #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    FRAME_WIDTH    = 320,
   parameter int                    FRAME_HEIGHT   = 480,
   parameter int                    ADDR_WIDTH     = 18,
   parameter int                    READ_LATENCY   = 2,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     s_address,
   input  logic                      s_chipselect,
   input  logic                      s_read,
   input  logic                      s_write,
   input  logic [DATA_WIDTH/8-1:0]   s_byteenable,
   input  logic [DATA_WIDTH-1:0]     s_writedata,
   output logic [DATA_WIDTH-1:0]     s_readdata,
   output logic                      s_readdatavalid,
   output logic                      s_waitrequest,
   input  logic                      scan_enable,
   input  logic                      stream_ready,
   output logic                      stream_valid,
   output logic [DATA_WIDTH-1:0]     stream_data,
   output logic                      stream_startofpacket,
   output logic                      stream_endofpacket,
   output logic                      clear_busy
);

   localparam int                    DEPTH  = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int                    BE_W   = DATA_WIDTH / 8;
   localparam int                    PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]         LAST   = PW'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN, S_DRAIN} state_t;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   state_t                r_state;
   logic                  r_clear_busy;
   logic [PW-1:0]         r_clr_addr;
   logic [PW-1:0]         r_scan_addr;
   logic                  r_stop;
   logic                  r_infl;
   logic                  r_b_sop;
   logic                  r_b_eop;
   logic [DATA_WIDTH-1:0] r_b_data;
   logic [1:0]            r_count;
   logic [DATA_WIDTH-1:0] r_head_data;
   logic                  r_head_sop;
   logic                  r_head_eop;
   logic [DATA_WIDTH-1:0] r_tail_data;
   logic                  r_tail_sop;
   logic                  r_tail_eop;
   logic [DATA_WIDTH-1:0] r_a_d1;
   logic [DATA_WIDTH-1:0] r_a_d2;
   logic                  r_a_v1;
   logic                  r_a_v2;

   logic                  w_a_wr;
   logic                  w_a_rd;
   logic                  w_a_inrange;
   logic [PW-1:0]         w_a_idx;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic                  w_b_last;
   logic                  w_rd_valid;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // A simultaneous read+write is a protocol error: the write wins and the read is dropped.
   assign w_a_wr      = s_chipselect & s_write & ~r_clear_busy;
   assign w_a_rd      = s_chipselect & s_read & ~s_write & ~r_clear_busy;
   assign w_a_inrange = (s_address <= LAST_A);
   assign w_a_idx     = s_address[PW-1:0];

   assign w_pop    = (r_count != 2'd0) & stream_ready;
   assign w_push   = r_infl;
   assign w_b_last = (r_scan_addr == LAST);
   assign w_issue  = (r_state == S_SCAN) &&
                     (({1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop}) < 3'd2);

   always_ff @(posedge clk) begin
      if (!reset && r_state == S_CLEAR) begin
         r_mem[r_clr_addr] <= CLEAR_VALUE;
      end else if (!reset && w_a_wr && w_a_inrange) begin
         for (int b = 0; b < BE_W; b++) begin
            if (s_byteenable[b]) r_mem[w_a_idx][b*8 +: 8] <= s_writedata[b*8 +: 8];
         end
      end
      // Both read ports sample before the write lands, so same-address reads see old data.
      r_a_d1 <= w_a_inrange ? r_mem[w_a_idx] : '0;
      if (w_issue) r_b_data <= r_mem[r_scan_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         r_clear_busy <= (CLEAR_ON_RESET != 0);
         r_clr_addr   <= '0;
         r_scan_addr  <= '0;
         r_stop       <= 1'b0;
         r_infl       <= 1'b0;
         r_b_sop      <= 1'b0;
         r_b_eop      <= 1'b0;
         r_count      <= 2'd0;
         r_head_data  <= '0;
         r_head_sop   <= 1'b0;
         r_head_eop   <= 1'b0;
         r_tail_data  <= '0;
         r_tail_sop   <= 1'b0;
         r_tail_eop   <= 1'b0;
         r_a_v1       <= 1'b0;
         r_a_v2       <= 1'b0;
         r_a_d2       <= '0;
      end else begin
         r_a_v1 <= w_a_rd;
         r_a_v2 <= r_a_v1;
         r_a_d2 <= r_a_d1;

         case (r_state)
            S_CLEAR: begin
               if (r_clr_addr == LAST) begin
                  r_state      <= S_IDLE;
                  r_clear_busy <= 1'b0;
                  r_clr_addr   <= '0;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            S_IDLE: begin
               r_scan_addr <= '0;
               r_stop      <= 1'b0;
               if (scan_enable) r_state <= S_SCAN;
            end
            S_SCAN: begin
               if (!scan_enable) r_stop <= 1'b1;
               // Stopping only after the last address keeps every frame complete.
               if (w_issue && w_b_last && (r_stop || !scan_enable)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_count == 2'd0 && !r_infl) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         r_infl <= w_issue;
         if (w_issue) begin
            r_b_sop     <= (r_scan_addr == '0);
            r_b_eop     <= w_b_last;
            r_scan_addr <= w_b_last ? '0 : r_scan_addr + 1'b1;
         end

         // The issue rule guarantees a push never arrives while the FIFO holds two entries.
         if (w_pop) begin
            if (r_count == 2'd2) begin
               r_head_data <= r_tail_data;
               r_head_sop  <= r_tail_sop;
               r_head_eop  <= r_tail_eop;
            end else if (w_push) begin
               r_head_data <= r_b_data;
               r_head_sop  <= r_b_sop;
               r_head_eop  <= r_b_eop;
            end
         end else if (w_push) begin
            if (r_count == 2'd0) begin
               r_head_data <= r_b_data;
               r_head_sop  <= r_b_sop;
               r_head_eop  <= r_b_eop;
            end else begin
               r_tail_data <= r_b_data;
               r_tail_sop  <= r_b_sop;
               r_tail_eop  <= r_b_eop;
            end
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign w_rd_valid = (READ_LATENCY == 1) ? r_a_v1 : r_a_v2;
   assign w_rd_data  = (READ_LATENCY == 1) ? r_a_d1 : r_a_d2;

   assign s_readdatavalid      = w_rd_valid;
   assign s_readdata           = w_rd_valid ? w_rd_data : '0;
   assign s_waitrequest        = r_clear_busy;
   assign clear_busy           = r_clear_busy;
   assign stream_valid         = (r_count != 2'd0);
   assign stream_data          = r_head_data;
   assign stream_startofpacket = r_head_sop;
   assign stream_endofpacket   = r_head_eop;

endmodule

// File: tb/tb_video_pixel_frame_buffer.sv
// tb/tb_video_pixel_frame_buffer.sv - self-checking bench for video_pixel_frame_buffer (16-bit, 4x2 frame)
// A frame-level model predicts slave reads and stream pixels; directed steps pin it with literals.
module tb_video_pixel_frame_buffer;

   localparam int          DW    = 16;
   localparam int          DEPTH = 8;
   localparam int          AW    = 4;
   localparam int          RL    = 2;
   localparam logic [15:0] CLR   = 16'hAAAA;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] s_address = '0;
   logic          s_chipselect = 1'b0;
   logic          s_read = 1'b0;
   logic          s_write = 1'b0;
   logic [1:0]    s_byteenable = '0;
   logic [DW-1:0] s_writedata = '0;
   logic [DW-1:0] s_readdata;
   logic          s_readdatavalid;
   logic          s_waitrequest;
   logic          scan_enable = 1'b0;
   logic          stream_ready = 1'b0;
   logic          stream_valid;
   logic [DW-1:0] stream_data;
   logic          stream_startofpacket;
   logic          stream_endofpacket;
   logic          clear_busy;

   always #5 clk = ~clk;

   video_pixel_frame_buffer #(
      .DATA_WIDTH(DW), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .ADDR_WIDTH(AW),
      .READ_LATENCY(RL), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
   ) dut (
      .clk(clk), .reset(reset),
      .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
      .s_byteenable(s_byteenable), .s_writedata(s_writedata),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
      .scan_enable(scan_enable), .stream_ready(stream_ready), .stream_valid(stream_valid),
      .stream_data(stream_data), .stream_startofpacket(stream_startofpacket),
      .stream_endofpacket(stream_endofpacket), .clear_busy(clear_busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   typedef struct { int due; logic [15:0] data; } rd_t;
   rd_t         rq[$];
   logic [15:0] m_mem [DEPTH];
   int          edge_n = 0;
   int          clear_left = 0;
   int          exp_pix = 0;
   bit          started = 0;
   bit          in_rst = 0;
   bit          prev_stall = 0;
   bit          m_busy = 0;
   bit          exp_v = 0;

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         in_rst = reset;
         if (in_rst) begin
            started    = 1;
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = CLR;
            rq.delete();
            exp_pix    = 0;
            prev_stall = 0;
         end else if (started) begin
            m_busy = (clear_left > 0);
            if (s_chipselect && s_write && !m_busy) begin
               if (int'(s_address) < DEPTH) begin
                  for (int b = 0; b < 2; b++)
                     if (s_byteenable[b]) m_mem[s_address][b*8 +: 8] = s_writedata[b*8 +: 8];
               end
            end else if (s_chipselect && s_read && !m_busy) begin
               rq.push_back('{due: edge_n + RL - 1,
                              data: (int'(s_address) < DEPTH) ? m_mem[s_address] : 16'h0000});
            end
            if (stream_valid && stream_ready) exp_pix = (exp_pix + 1) % DEPTH;
            prev_stall = stream_valid && !stream_ready;
            if (clear_left > 0) clear_left--;
         end
         @(negedge clk);
         if (started) begin
            chk("clear_busy", 32'(clear_busy), 32'(clear_left > 0));
            chk("waitrequest", 32'(s_waitrequest), 32'(clear_left > 0));
            exp_v = (rq.size() > 0) && (rq[0].due == edge_n);
            chk("rd_valid", 32'(s_readdatavalid), 32'(exp_v));
            if (exp_v) begin
               chk("rd_data", 32'(s_readdata), 32'(rq[0].data));
               void'(rq.pop_front());
            end
            if (in_rst) begin
               chk("valid_after_reset", 32'(stream_valid), 32'd0);
            end else begin
               if (prev_stall) chk("hold_valid", 32'(stream_valid), 32'd1);
               if (stream_valid) begin
                  chk("pix_data", 32'(stream_data), 32'(m_mem[exp_pix]));
                  chk("pix_sop", 32'(stream_startofpacket), 32'(exp_pix == 0));
                  chk("pix_eop", 32'(stream_endofpacket), 32'(exp_pix == DEPTH - 1));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
      s_chipselect = 1; s_write = 1; s_address = a; s_writedata = d; s_byteenable = be;
      tick();
      s_chipselect = 0; s_write = 0;
   endtask

   task automatic read_lit(input string name, input logic [AW-1:0] a, input logic [15:0] expd);
      int n;
      s_chipselect = 1; s_read = 1; s_address = a;
      tick();
      s_chipselect = 0; s_read = 0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n++;
         if (s_readdatavalid) break;
      end
      chk({name, "_lat"}, 32'(n), 32'(RL));
      chk(name, 32'(s_readdata), 32'(expd));
   endtask

   task automatic count_clear(input string name);
      int cnt;
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!clear_busy) break;
         cnt++;
      end
      chk(name, 32'(cnt), 32'd8);
   endtask

   // Called right after a posedge: raises scan_enable and expects the first pixel on the 4th falling edge.
   task automatic scan_start(input string name, input logic [15:0] first);
      int n;
      scan_enable = 1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (stream_valid) break;
      end
      chk({name, "_lat"}, 32'(n), 32'd4);
      chk({name, "_data"}, 32'(stream_data), 32'(first));
      chk({name, "_sop"}, 32'(stream_startofpacket), 32'd1);
   endtask

   task automatic wait_pixel(input string name, input logic [15:0] pix);
      bit found;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stream_valid && stream_data == pix) begin
            found = 1;
            break;
         end
      end
      chk(name, 32'(found), 32'd1);
   endtask

   initial begin
      int got;
      bit last_eop;

      tick();
      reset = 0;
      s_chipselect = 1; s_read = 1; s_address = 4'd5;
      @(negedge clk);
      chk("rst_readdata", 32'(s_readdata), 32'd0);
      chk("rst_readdatavalid", 32'(s_readdatavalid), 32'd0);
      chk("rst_stream_valid", 32'(stream_valid), 32'd0);
      chk("rst_stream_data", 32'(stream_data), 32'd0);
      chk("rst_sop", 32'(stream_startofpacket), 32'd0);
      chk("rst_eop", 32'(stream_endofpacket), 32'd0);
      chk("rst_clear_busy", 32'(clear_busy), 32'd1);
      count_clear("clear_cycles");
      tick();
      s_chipselect = 0; s_read = 0;
      repeat (3) tick();

      for (int i = 0; i < DEPTH; i++) begin
         s_chipselect = 1; s_read = 1; s_address = AW'(i);
         tick();
      end
      s_chipselect = 0; s_read = 0;
      repeat (3) tick();
      read_lit("rd_clear_val", 4'd6, 16'hAAAA);

      wr(4'd3, 16'h1234, 2'b10);
      read_lit("rd_byteenable", 4'd3, 16'h12AA);
      read_lit("rd_out_of_range", 4'd9, 16'h0000);
      wr(4'd9, 16'hBEEF, 2'b11);
      read_lit("rd_oor_after_write", 4'd1, 16'hAAAA);

      s_chipselect = 1; s_read = 1; s_write = 1; s_address = 4'd4;
      s_writedata = 16'h5555; s_byteenable = 2'b11;
      tick();
      s_chipselect = 0; s_read = 0; s_write = 0;
      repeat (3) tick();
      read_lit("rd_rw_conflict", 4'd4, 16'h5555);

      for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'(i), 2'b11);
      tick();

      stream_ready = 1;
      scan_start("scan1", 16'h0000);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         chk("nobubble_valid", 32'(stream_valid), 32'd1);
         chk("nobubble_data", 32'(stream_data), 32'(i % 8));
         chk("nobubble_sop", 32'(stream_startofpacket), 32'(i % 8 == 0));
         chk("nobubble_eop", 32'(stream_endofpacket), 32'(i % 8 == 7));
      end

      for (int i = 0; i < 60; i++) begin
         tick();
         stream_ready = 1'($urandom_range(0, 1));
      end
      tick();
      stream_ready = 1;

      wait_pixel("find_pixel3", 16'd3);
      tick();
      scan_enable = 0;
      got = 0;
      last_eop = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (stream_valid) begin
            got++;
            chk("drain_seq", 32'(stream_data), 32'(3 + got));
            last_eop = stream_endofpacket;
         end
      end
      chk("drain_count", 32'(got), 32'd4);
      chk("drain_last_eop", 32'(last_eop), 32'd1);
      tick();
      scan_start("rescan", 16'h0000);

      wait_pixel("find_pixel5", 16'd5);
      tick();
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      chk("midrst_valid", 32'(stream_valid), 32'd0);
      chk("midrst_busy", 32'(clear_busy), 32'd1);
      count_clear("clear_cycles_again");
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stream_valid) begin
            got = 1;
            break;
         end
      end
      chk("restart_seen", 32'(got), 32'd1);
      chk("restart_data", 32'(stream_data), 32'(CLR));
      chk("restart_sop", 32'(stream_startofpacket), 32'd1);
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/video_pixel_frame_buffer.md
Name: video_pixel_frame_buffer

Overview:
Parametrised on-chip pixel frame buffer for the SoC video system.
- Avalon-MM slave port: CPU/DMA read/write with byte enables and pipelined reads.
- Second internal RAM port: hardware clear on reset, then continuous raster scanout as an Avalon-ST pixel stream with sop/eop and ready/valid backpressure.
- Sits between the system interconnect and the video output pipeline.

Parameters:
DATA_WIDTH, 8, pixel/word width in bits; must be a multiple of 8.
FRAME_WIDTH, 320, pixels per line.
FRAME_HEIGHT, 480, lines per frame; DEPTH = FRAME_WIDTH*FRAME_HEIGHT (default 153600).
ADDR_WIDTH, 18, slave address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
READ_LATENCY, 2, slave read latency in cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = fill RAM with CLEAR_VALUE after reset.
CLEAR_VALUE, 0, word written during clear.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
s_address  in  ADDR_WIDTH  word address.
s_chipselect  in  1  slave select.
s_read  in  1  read request (qualified by s_chipselect).
s_write  in  1  write request (qualified by s_chipselect).
s_byteenable  in  DATA_WIDTH/8  write byte lanes.
s_writedata  in  DATA_WIDTH  write data.
s_readdata  out  DATA_WIDTH  read data.
s_readdatavalid  out  1  read data valid.
s_waitrequest  out  1  slave stall.
scan_enable  in  1  level; request continuous scanout.
stream_ready  in  1  sink ready.
stream_valid  out  1  pixel valid.
stream_data  out  DATA_WIDTH  pixel.
stream_startofpacket  out  1  first pixel of frame.
stream_endofpacket  out  1  last pixel of frame.
clear_busy  out  1  clear in progress.

Behaviour:
- Reset values: s_readdata=0, s_readdatavalid=0, stream_valid=0, stream_data=0, sop=0, eop=0, clear_busy=CLEAR_ON_RESET.
- s_waitrequest=clear_busy. Reset in any state flushes all pipelines and the output FIFO, zeroes counters, and re-enters CLEAR or IDLE.
- FSM states: CLEAR, IDLE, SCAN, DRAIN.
- CLEAR: port B writes CLEAR_VALUE to addresses 0..DEPTH-1, one per cycle; exits to IDLE after exactly DEPTH cycles; clear_busy falls with the transition. With CLEAR_ON_RESET=0, reset goes directly to IDLE.
- IDLE -> SCAN when scan_enable=1; the scan counter starts at 0.
- SCAN: port B reads have 1-cycle latency and feed a 2-entry output FIFO.
  - A read issues when (fifo_count + inflight - pop) < 2, where pop = stream_valid & stream_ready.
  - With stream_ready held high: first pixel 2 cycles after entering SCAN, then 1 pixel/cycle with no bubbles.
  - Counter wraps DEPTH-1 -> 0 with no gap. sop is tagged on address 0, eop on address DEPTH-1.
- scan_enable=0 seen in SCAN: issue continues up to and including address DEPTH-1, then DRAIN. Frames are never truncated.
- DRAIN: no issue; -> IDLE when the FIFO and the read pipe are empty.
- Stream handshake: stream_data/sop/eop are held stable while stream_valid=1 and stream_ready=0.
- Slave writes: an accepted write (chipselect & write & ~waitrequest) updates only the bytes enabled in s_byteenable. Addresses >= DEPTH are ignored.
- Slave reads: an accepted read returns data exactly READ_LATENCY cycles later with a 1-cycle s_readdatavalid pulse; back-to-back reads are accepted every cycle.
  - Out-of-range reads return 0 with valid.
  - Read and write on the same cycle (both asserted) is a protocol error; the write takes priority and no read is returned.
- Read-during-write, same address: a slave read and a scan read both return old data.
- Requests during CLEAR are stalled, not dropped.

Test Plan:
- DATA_WIDTH=8, 4x2 frame (DEPTH=8), CLEAR_VALUE=8'hAA, reset 1 cycle -> clear_busy=1 for exactly 8 cycles; then 8 slave reads return 8'hAA at READ_LATENCY.
- DATA_WIDTH=16: write 16'h1234 to addr 3 with byteenable 2'b10, then read addr 3 -> 16'h12AA (CLEAR_VALUE=16'hAAAA); read addr 9 -> 0.
- Load addr n with value n, scan_enable=1, stream_ready=1 -> stream 0..7,0..7 with no bubbles; sop only with 0, eop only with 7.
- stream_ready toggled randomly at 50% -> pixel sequence unchanged, data held during stalls, no loss or duplication.
- Drop scan_enable at pixel 3 -> pixels 4..7 still delivered, eop on 7, then stream_valid=0 and the FSM is in IDLE.
- Assert reset mid-frame at pixel 5 -> stream_valid=0 the next cycle, clear re-runs, and the restarted scan begins at pixel 0 with sop.
